// File: rtl/imem_responder_pkg.sv
// Shared constants and the response-bundle layout for the instruction-memory responder.
// Used by imem_responder, imem_resp_pipe and the fetch-side benches.
package imem_responder_pkg;

    localparam logic [31:0] IMEM_FAULT_WORD = 32'h0000_0000;
    localparam logic [31:0] IMEM_NOP        = 32'h0000_0013;
    localparam int          LATENCY_MAX     = 4;

    // Bundle bit layout, MSB first: {fault, data[31:0], valid}
    typedef struct packed {
        logic        fault;
        logic [31:0] data;
        logic        valid;
    } imem_bundle_t;

endpackage

// File: rtl/imem_resp_pipe.sv
// In-order, never-stalling response pipe: LATENCY stages of response bundles, asynchronously cleared.
// Stage 0 keeps its data word across bubbles so the output holds the last valid instruction.
module imem_resp_pipe
    import imem_responder_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic         clk,
    input  logic         resetb,
    input  imem_bundle_t i_bundle,
    output imem_bundle_t o_bundle
);

    imem_bundle_t [LATENCY-1:0] r_stage;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_stage <= '0;
        end else begin
            r_stage[0].valid <= i_bundle.valid;
            r_stage[0].fault <= i_bundle.fault;
            if (i_bundle.valid) begin
                r_stage[0].data <= i_bundle.data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_bundle = r_stage[LATENCY-1];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: word array, loader write port, request capture and fixed-latency replies.
// Optional address bounds checking is compiled in with `define IMEM_BOUNDS_CHK_EN.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic                     imem_ready,
    input  logic [31:0]              imem_addr,
    output logic                     imem_valid,
    output logic [31:0]              imem_rdata,
    output logic                     imem_fault,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_wdata
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] w_idx;
    logic          w_fault;
    imem_bundle_t  w_req;
    imem_bundle_t  w_resp;

    assign w_idx = imem_addr[AW+1:2];

    // Contents are deliberately not reset; only the response pipe is.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            r_mem[ld_addr] <= ld_wdata;
        end
    end

`ifdef IMEM_BOUNDS_CHK_EN
    assign w_fault = (imem_addr[1:0] != 2'b00) || ((imem_addr >> (AW + 2)) != 32'd0);
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{imem_addr[31:AW+2], imem_addr[1:0]};
    assign w_fault       = 1'b0;
`endif

    // The array read is registered by pipe stage 0, so a same-edge loader write returns the old word.
    always_comb begin
        w_req       = '0;
        w_req.valid = imem_ready;
        w_req.fault = imem_ready & w_fault;
        w_req.data  = (imem_ready & w_fault) ? IMEM_FAULT_WORD : r_mem[w_idx];
    end

    imem_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk      (clk),
        .resetb   (resetb),
        .i_bundle (w_req),
        .o_bundle (w_resp)
    );

    assign imem_valid = w_resp.valid;
    assign imem_rdata = w_resp.data;
    assign imem_fault = w_resp.fault;

endmodule
